// File: rtl/reset_sequencer_pkg.sv
// Shared state encoding and width helpers for the staged reset sequencer.
package reset_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_RETRY  = 3'd4,
    ST_DEAD   = 3'd5,
    ST_REQD   = 3'd6
  } seq_state_t;

  // floor(log2(value))+1, never less than one bit
  function automatic int log2_width(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((value >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_seq_timer.sv
// Loadable down-counter with a zero flag; holds at zero rather than wrapping.
module seq_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - ONE;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Releases per-subsystem resets one stage at a time, supervises released stages,
// retries on timeout or ready loss and issues soft reset pulses to the generator.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int  NUM_STAGES    = 3,
  parameter int  STAGE_DELAY   = 255,
  parameter int  READY_TIMEOUT = 65535,
  parameter int  MAX_RETRY     = 3,
  localparam int IDX_W         = log2_width(NUM_STAGES - 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_STAGES-1:0] stage_ready,
  input  logic                  soft_reset_req,
  output logic [NUM_STAGES-1:0] stage_reset,
  output logic                  int_reset,
  output logic                  busy,
  output logic                  running,
  output logic                  fault,
  output logic [IDX_W-1:0]      fault_stage
);

  // state  | meaning
  // HOLD   | all stages in reset, waiting for the first edge out of reset
  // WAIT   | stage idx released, waiting for its ready (timeout armed)
  // SETTLE | stage idx ready, settle delay before the next release
  // RUN    | every stage released and ready
  // RETRY  | all stages back in reset, delay before resequencing
  // DEAD   | retries exhausted, fault latched
  // REQD   | soft reset pulse issued, holding until reset arrives

  localparam int TMR_W = log2_width(max_int(STAGE_DELAY, READY_TIMEOUT));
  localparam int RTY_W = log2_width(MAX_RETRY);

  localparam logic [TMR_W-1:0] DELAY_LD   = TMR_W'(STAGE_DELAY);
  localparam logic [TMR_W-1:0] TIMEOUT_LD = TMR_W'(READY_TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_STAGES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
  localparam logic [RTY_W-1:0] RETRY_MAX  = RTY_W'(MAX_RETRY);
  localparam logic [RTY_W-1:0] RETRY_ONE  = RTY_W'(1);

  seq_state_t            state, state_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [RTY_W-1:0]      retry_cnt, retry_cnt_nxt;
  logic [NUM_STAGES-1:0] stage_reset_nxt;
  logic                  int_reset_nxt, busy_nxt, running_nxt, fault_nxt;
  logic [IDX_W-1:0]      fault_stage_nxt;

  logic                  tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0]      tmr_load_val;

  logic [NUM_STAGES-1:0] idx_onehot, next_onehot, supervised, lost;
  logic                  lost_any, ready_cur;
  logic [IDX_W-1:0]      lost_idx;

  seq_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    idx_onehot  = '0;
    next_onehot = '0;
    for (int j = 0; j < NUM_STAGES; j++) begin
      idx_onehot[j]  = (idx == IDX_W'(j));
      next_onehot[j] = ((idx + IDX_ONE) == IDX_W'(j));
    end
  end

  // Released stages other than the one still being waited on must stay ready.
  always_comb begin
    supervised = '0;
    case (state)
      ST_WAIT:           supervised = ~stage_reset & ~idx_onehot;
      ST_SETTLE, ST_RUN: supervised = ~stage_reset;
      default:           supervised = '0;
    endcase
    lost     = supervised & ~stage_ready;
    lost_any = |lost;
    lost_idx = '0;
    for (int j = NUM_STAGES - 1; j >= 0; j--) begin
      if (lost[j]) lost_idx = IDX_W'(j);
    end
    ready_cur = |(stage_ready & idx_onehot);
  end

  always_comb begin
    logic             do_fail;
    logic [IDX_W-1:0] fail_stage;

    state_nxt       = state;
    idx_nxt         = idx;
    retry_cnt_nxt   = retry_cnt;
    stage_reset_nxt = stage_reset;
    int_reset_nxt   = 1'b0;
    busy_nxt        = busy;
    running_nxt     = running;
    fault_nxt       = fault;
    fault_stage_nxt = fault_stage;
    tmr_load        = 1'b0;
    tmr_load_val    = TIMEOUT_LD;
    tmr_dec         = 1'b0;
    do_fail         = 1'b0;
    fail_stage      = '0;

    case (state)
      ST_HOLD: begin
        stage_reset_nxt[0] = 1'b0;
        tmr_load           = 1'b1;
        tmr_load_val       = TIMEOUT_LD;
        state_nxt          = ST_WAIT;
      end
      ST_WAIT: begin
        if (lost_any) begin
          do_fail    = 1'b1;
          fail_stage = lost_idx;
        end else if (ready_cur) begin
          tmr_load     = 1'b1;
          tmr_load_val = DELAY_LD;
          state_nxt    = ST_SETTLE;
        end else if (tmr_zero) begin
          do_fail    = 1'b1;
          fail_stage = idx;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (lost_any) begin
          do_fail    = 1'b1;
          fail_stage = lost_idx;
        end else if (tmr_zero) begin
          if (idx == LAST_IDX) begin
            busy_nxt    = 1'b0;
            running_nxt = 1'b1;
            state_nxt   = ST_RUN;
          end else begin
            idx_nxt         = idx + IDX_ONE;
            stage_reset_nxt = stage_reset & ~next_onehot;
            tmr_load        = 1'b1;
            tmr_load_val    = TIMEOUT_LD;
            state_nxt       = ST_WAIT;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_RUN: begin
        if (lost_any) begin
          do_fail    = 1'b1;
          fail_stage = lost_idx;
        end else if (soft_reset_req) begin
          int_reset_nxt = 1'b1;
          state_nxt     = ST_REQD;
        end
      end
      ST_RETRY: begin
        if (tmr_zero) begin
          idx_nxt            = '0;
          stage_reset_nxt[0] = 1'b0;
          tmr_load           = 1'b1;
          tmr_load_val       = TIMEOUT_LD;
          state_nxt          = ST_WAIT;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_DEAD: begin
        if (soft_reset_req) begin
          int_reset_nxt = 1'b1;
          state_nxt     = ST_REQD;
        end
      end
      ST_REQD: begin
        state_nxt = ST_REQD;
      end
      default: begin
        state_nxt = ST_HOLD;
      end
    endcase

    if (do_fail) begin
      stage_reset_nxt = '1;
      fault_stage_nxt = fail_stage;
      running_nxt     = 1'b0;
      if (retry_cnt == RETRY_MAX) begin
        fault_nxt = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = ST_DEAD;
      end else begin
        retry_cnt_nxt = retry_cnt + RETRY_ONE;
        busy_nxt      = 1'b1;
        tmr_load      = 1'b1;
        tmr_load_val  = DELAY_LD;
        state_nxt     = ST_RETRY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_HOLD;
      idx         <= '0;
      retry_cnt   <= '0;
      stage_reset <= '1;
      int_reset   <= 1'b0;
      busy        <= 1'b1;
      running     <= 1'b0;
      fault       <= 1'b0;
      fault_stage <= '0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      retry_cnt   <= retry_cnt_nxt;
      stage_reset <= stage_reset_nxt;
      int_reset   <= int_reset_nxt;
      busy        <= busy_nxt;
      running     <= running_nxt;
      fault       <= fault_nxt;
      fault_stage <= fault_stage_nxt;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: a procedural reference model predicts every output change,
// a negedge monitor compares each observed change against the queued prediction.
module tb_reset_sequencer;

  localparam int N = 3, SD = 4, RT = 16, MR = 2, FW = 2, VW = N + 4 + FW, NEVER = 1000;
  localparam logic [VW-1:0] RESET_VEC = {3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};

  logic clk = 1'b0, reset = 1'b1, soft_reset_req = 1'b0;
  logic [N-1:0] stage_ready = '0;
  logic [N-1:0] stage_reset;
  logic int_reset, busy, running, fault;
  logic [FW-1:0] fault_stage;
  logic [VW-1:0] dut_vec;

  reset_sequencer #(
    .NUM_STAGES(N), .STAGE_DELAY(SD), .READY_TIMEOUT(RT), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .reset(reset), .stage_ready(stage_ready), .soft_reset_req(soft_reset_req),
    .stage_reset(stage_reset), .int_reset(int_reset), .busy(busy), .running(running),
    .fault(fault), .fault_stage(fault_stage)
  );

  always #5 clk = ~clk;
  assign dut_vec = {stage_reset, int_reset, busy, running, fault, fault_stage};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;

  typedef struct { int cyc; logic [VW-1:0] v; } ev_t;
  ev_t exp_q[$];

  // ---------------- reference model ----------------
  logic [N-1:0]  m_sr;
  logic          m_int, m_busy, m_run, m_fault;
  logic [FW-1:0] m_fs;
  int            m_retry;
  logic [VW-1:0] last_pub;
  logic          s_reset, s_req;
  logic [N-1:0]  s_rdy;

  function automatic logic [VW-1:0] m_vec();
    return {m_sr, m_int, m_busy, m_run, m_fault, m_fs};
  endfunction

  task automatic set_reset_vals();
    m_sr = '1; m_int = 1'b0; m_busy = 1'b1; m_run = 1'b0; m_fault = 1'b0; m_fs = '0; m_retry = 0;
  endtask

  task automatic publish();
    logic [VW-1:0] v;
    v = m_vec();
    if (v !== last_pub) begin
      exp_q.push_back('{cyc + 1, v});
      last_pub = v;
    end
  endtask

  task automatic model_edge();
    @(posedge clk);
    s_reset = reset; s_rdy = stage_ready; s_req = soft_reset_req;
    m_int = 1'b0;
  endtask

  function automatic int lost_stage(input logic [N-1:0] mask);
    for (int j = 0; j < N; j++) if (mask[j] && !s_rdy[j]) return j;
    return -1;
  endfunction

  // after a soft reset pulse nothing changes until reset
  task automatic model_hold();
    forever begin
      model_edge();
      if (s_reset) return;
      publish();
    end
  endtask

  task automatic model_dead();
    forever begin
      model_edge();
      if (s_reset) return;
      if (s_req) begin m_int = 1'b1; publish(); model_hold(); return; end
      publish();
    end
  endtask

  // one pass over all stages, then run; returns on reset or on a fault
  task automatic model_attempt(output bit got_reset, output int fs);
    logic [N-1:0] wmask;
    int waited;
    bit ok;
    got_reset = 1'b0;
    fs = -1;
    for (int i = 0; i < N; i++) begin
      wmask = '0; wmask[i] = 1'b1;
      waited = 0; ok = 1'b0;
      while (!ok) begin
        model_edge();
        if (s_reset) begin got_reset = 1'b1; return; end
        fs = lost_stage(~m_sr & ~wmask);
        if (fs >= 0) return;
        if (s_rdy[i]) ok = 1'b1;
        else if (waited == RT) begin fs = i; return; end
        else waited++;
        publish();
      end
      for (int k = 1; k <= SD + 1; k++) begin
        model_edge();
        if (s_reset) begin got_reset = 1'b1; return; end
        fs = lost_stage(~m_sr);
        if (fs >= 0) return;
        if (k == SD + 1) begin
          if (i == N - 1) begin m_busy = 1'b0; m_run = 1'b1; end
          else m_sr[i + 1] = 1'b0;
        end
        publish();
      end
    end
    forever begin
      model_edge();
      if (s_reset) begin got_reset = 1'b1; return; end
      fs = lost_stage(~m_sr);
      if (fs >= 0) return;
      if (s_req) begin
        m_int = 1'b1; publish();
        model_hold();
        got_reset = 1'b1;
        return;
      end
      publish();
    end
  endtask

  initial begin : ref_model
    bit gr;
    int fs;
    bit stop;
    set_reset_vals();
    last_pub = m_vec();
    forever begin
      model_edge();
      while (s_reset) begin set_reset_vals(); publish(); model_edge(); end
      m_sr[0] = 1'b0;
      publish();
      stop = 1'b0;
      while (!stop) begin
        model_attempt(gr, fs);
        if (gr) stop = 1'b1;
        else begin
          m_sr = '1; m_fs = FW'(fs); m_run = 1'b0;
          if (m_retry == MR) begin
            m_fault = 1'b1; m_busy = 1'b0; publish();
            model_dead();
            stop = 1'b1;
          end else begin
            m_retry++; m_busy = 1'b1; publish();
            for (int k = 1; k <= SD + 1 && !stop; k++) begin
              model_edge();
              if (s_reset) stop = 1'b1;
              else begin
                if (k == SD + 1) m_sr[0] = 1'b0;
                publish();
              end
            end
          end
        end
      end
      set_reset_vals();
      publish();
    end
  end

  // ---------------- monitor ----------------
  logic [VW-1:0] mon_prev = RESET_VEC;
  always @(negedge clk) begin
    ev_t e;
    if (dut_vec !== mon_prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cycle %0d: got %b, required no change from %b",
                 cyc, dut_vec, mon_prev);
      end else begin
        e = exp_q.pop_front();
        if (e.v !== dut_vec || e.cyc != cyc) begin
          errors++;
          $display("FAIL output_event: got %b at cycle %0d, required %b at cycle %0d",
                   dut_vec, cyc, e.v, e.cyc);
        end
      end
      mon_prev = dut_vec;
    end
  end

  // ---------------- stimulus ----------------
  int lat[N];
  int rcnt[N];
  logic [N-1:0] drop = '0;

  task automatic step();
    @(posedge clk);
    #1;
    for (int j = 0; j < N; j++) begin
      if (stage_reset[j] !== 1'b0) rcnt[j] = 0;
      else if (rcnt[j] < 2000) rcnt[j]++;
      stage_ready[j] = (lat[j] != NEVER) && (rcnt[j] >= lat[j]) && !drop[j];
    end
    drop = '0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic start(input int l0, input int l1, input int l2);
    lat[0] = l0; lat[1] = l1; lat[2] = l2;
    soft_reset_req = 1'b0;
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
  endtask

  initial begin
    for (int j = 0; j < N; j++) begin lat[j] = 3; rcnt[j] = 0; end
    @(negedge clk);
    checks++;
    if (dut_vec !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_state: got %b, required %b", dut_vec, RESET_VEC);
    end

    // clean sequence, then a one-cycle ready drop in RUN, then a held soft reset request
    start(3, 3, 3);
    steps(50);
    drop = 3'b001;
    step();
    steps(60);
    soft_reset_req = 1'b1;
    steps(10);
    soft_reset_req = 1'b0;
    steps(3);

    // stage 1 never ready: retries exhausted, then soft reset from DEAD
    start(3, NEVER, 3);
    steps(140);
    soft_reset_req = 1'b1;
    steps(2);
    soft_reset_req = 1'b0;
    steps(3);

    // reset pulsed during settle of stage 1
    start(3, 3, 3);
    steps(13);
    reset = 1'b1;
    step();
    reset = 1'b0;
    steps(50);

    // stage 2 ready exactly on its timeout edge, and one cycle too late
    start(3, 3, RT + 1);
    steps(70);
    start(2, 2, RT + 2);
    steps(60);

    // randomized latencies, drops and soft reset requests
    for (int r = 0; r < 8; r++) begin
      start(($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(1, 8),
            ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(1, 18),
            $urandom_range(1, 18));
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(0, 39) == 0) drop[$urandom_range(0, N - 1)] = 1'b1;
        soft_reset_req = ($urandom_range(0, 59) == 0);
        step();
      end
    end

    soft_reset_req = 1'b0;
    steps(10);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d unmatched predictions, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
